enc_bin2gray: RTL and testbench



---
 rtl/enc_bin2gray.sv | 75 +++++++
 tb/tb_enc_bin2gray.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/enc_bin2gray.sv
// Binary-to-Gray encoder: combinational code plus a valid-qualified registered copy with adjacency flag.
// Optional Gray-to-binary decode of the registered code enabled by ENC_BIN2GRAY_DECODE_EN.
module enc_bin2gray #(
   parameter int unsigned WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray,
   input  logic             in_valid,
   output logic [WIDTH-1:0] gray_q,
   output logic             out_valid,
   output logic             adj_q,
   output logic [WIDTH-1:0] dec_q
);

   logic [WIDTH-1:0] code_d;
   logic             out_valid_d;
   logic             adj_d;
   logic             have_prev_q;
   logic             have_prev_d;
   logic [WIDTH-1:0] diff_c;
   logic             one_bit_c;

   // Purely combinational, independent of clock and reset
   assign gray = bin ^ (bin >> 1);

   // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero
   assign diff_c    = gray ^ gray_q;
   assign one_bit_c = (diff_c != '0) && ((diff_c & (diff_c - WIDTH'(1))) == '0);

   // Next-state for the capture path; history only updates on a capture
   always_comb begin
      code_d      = gray_q;
      out_valid_d = 1'b0;
      adj_d       = adj_q;
      have_prev_d = have_prev_q;
      if (in_valid) begin
         code_d      = gray;
         out_valid_d = 1'b1;
         adj_d       = one_bit_c && have_prev_q;
         have_prev_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gray_q      <= '0;
         out_valid   <= 1'b0;
         adj_q       <= 1'b0;
         have_prev_q <= 1'b0;
      end else begin
         gray_q      <= code_d;
         out_valid   <= out_valid_d;
         adj_q       <= adj_d;
         have_prev_q <= have_prev_d;
      end
   end

`ifdef ENC_BIN2GRAY_DECODE_EN
   // Prefix XOR from the MSB down reconstructs the captured binary value
   always_comb begin
      logic acc;
      acc   = 1'b0;
      dec_q = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         acc      = acc ^ gray_q[i];
         dec_q[i] = acc;
      end
   end
`else
   assign dec_q = '0;
`endif

endmodule

// File: tb/tb_enc_bin2gray.sv
// Self-checking bench for enc_bin2gray: combinational sweeps plus a scoreboarded registered path.
module tb_enc_bin2gray;

   localparam int unsigned W = 10;
`ifdef ENC_BIN2GRAY_DECODE_EN
   localparam bit DEC = 1'b1;
`else
   localparam bit DEC = 1'b0;
`endif

   typedef struct packed {
      logic [W-1:0] g;
      logic         v;
      logic         a;
      logic [W-1:0] d;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] bin;
   logic [W-1:0] gray;
   logic         in_valid;
   logic [W-1:0] gray_q;
   logic         out_valid;
   logic         adj_q;
   logic [W-1:0] dec_q;

   int checks   = 0;
   int failures = 0;

   exp_t         sb[$];
   logic [W-1:0] m_gray;
   logic         m_have_prev;
   logic         m_adj;
   logic [W-1:0] m_dec;

   enc_bin2gray #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .bin(bin), .gray(gray), .in_valid(in_valid),
      .gray_q(gray_q), .out_valid(out_valid), .adj_q(adj_q), .dec_q(dec_q)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle at a falling edge, push the model's expectation, compare at the next falling edge
   task automatic step(input string tag, input logic vld, input logic [W-1:0] b);
      exp_t e;
      logic [W-1:0] g;
      bin      = b;
      in_valid = vld;
      g        = b ^ (b >> 1);
      if (vld) begin
         m_adj       = m_have_prev && ($countones(g ^ m_gray) == 1);
         m_gray      = g;
         m_have_prev = 1'b1;
         m_dec       = DEC ? b : '0;
      end
      e.g = m_gray; e.v = vld; e.a = m_adj; e.d = m_dec;
      sb.push_back(e);
      @(negedge clk);
      checks++;
      assert (sb.size() == 1) else begin
         failures++;
         $error("FAIL %s_sb_depth observed=%0d expected=1", tag, sb.size());
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, "_gray_q"}, 32'(gray_q), 32'(e.g));
         chk({tag, "_out_valid"}, 32'(out_valid), 32'(e.v));
         chk({tag, "_adj_q"}, 32'(adj_q), 32'(e.a));
         chk({tag, "_dec_q"}, 32'(dec_q), 32'(e.d));
      end
   endtask

   logic [W-1:0] dir_bin [10] = '{10'h000, 10'h001, 10'h3FF, 10'h2AA, 10'h200,
                                  10'h002, 10'h003, 10'h004, 10'h2D3, 10'h12C};
   logic [W-1:0] dir_gray[10] = '{10'h000, 10'h001, 10'h200, 10'h3FF, 10'h300,
                                  10'h003, 10'h002, 10'h006, 10'h3BA, 10'h1BA};

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; bin = '0;
      m_gray = '0; m_have_prev = 1'b0; m_adj = 1'b0; m_dec = '0;
      #1;
      chk("rst_gray_q", 32'(gray_q), 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_adj_q", 32'(adj_q), 32'h0);
      chk("rst_dec_q", 32'(dec_q), 32'h0);

      // Directed combinational values, then exhaustive with reset held
      for (int i = 0; i < 10; i++) begin
         bin = dir_bin[i];
         #1;
         chk($sformatf("comb_%03h", dir_bin[i]), 32'(gray), 32'(dir_gray[i]));
      end
      for (int i = 0; i < 1024; i++) begin
         bin = W'(i);
         #1;
         chk("comb_exh", 32'(gray), 32'(i ^ (i >> 1)));
      end

      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      step("cap_bin2", 1'b1, 10'd2);
      step("cap_bin3", 1'b1, 10'd3);
      step("cap_bin1", 1'b1, 10'd1);
      step("cap_bin4", 1'b1, 10'd4);
      step("idle", 1'b0, 10'd7);
      step("idle2", 1'b0, 10'd9);
      step("cap_same4", 1'b1, 10'd4);
      step("cap_same4b", 1'b1, 10'd4);
      step("cap_3ff", 1'b1, 10'h3FF);
      step("cap_wrap0", 1'b1, 10'h000);
      step("cap_2d3", 1'b1, 10'h2D3);
      step("cap_12c", 1'b1, 10'h12C);
      step("idle3", 1'b0, 10'h000);

      // Asynchronous reset between captures clears outputs and history
      #2;
      rst_n = 1'b0;
      bin   = 10'h2AA;
      #1;
      chk("mid_rst_gray_q", 32'(gray_q), 32'h0);
      chk("mid_rst_out_valid", 32'(out_valid), 32'h0);
      chk("mid_rst_adj_q", 32'(adj_q), 32'h0);
      chk("mid_rst_dec_q", 32'(dec_q), 32'h0);
      chk("mid_rst_gray", 32'(gray), 32'h3FF);
      m_gray = '0; m_have_prev = 1'b0; m_adj = 1'b0; m_dec = '0;
      @(negedge clk);
      rst_n = 1'b1;
      step("post_rst_bin3", 1'b1, 10'd3);
      step("post_rst_bin2", 1'b1, 10'd2);
      step("post_rst_idle", 1'b0, 10'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
